// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and its integration in the CPU.
// Sequencer state encoding, the canonical NOP and a small state-decode helper.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } seq_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // RUN and STEP are the only states allowed to hand an instruction to EX.
    function automatic logic is_issue_state(input seq_state_t st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/status bundle between the fetch sequencer and the surrounding pipeline/debug logic.
// The slave modport is the sequencer's view; master is the core/debug side.
interface fetch_sequencer_if #(
    parameter int AW    = 12,
    parameter int CNT_W = 32
);
    logic             redirect_EX;
    logic [AW-1:0]    target_EX;
    logic             halt_req;
    logic             step_req;
    logic [AW-1:0]    PC_FETCH;
    logic             issue_EX;
    logic             flush_EX;
    logic             halted;
    logic [CNT_W-1:0] instret;

    modport master (
        output redirect_EX, target_EX, halt_req, step_req,
        input  PC_FETCH, issue_EX, flush_EX, halted, instret
    );

    modport slave (
        input  redirect_EX, target_EX, halt_req, step_req,
        output PC_FETCH, issue_EX, flush_EX, halted, instret
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer for the FETCH/EX pipeline: redirects, wrong-path kill, halt/step debug
// control and a retired-instruction counter.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int            AW       = 12,
    parameter int            CNT_W    = 32,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    fetch_sequencer_if.slave bus
);

    seq_state_t       state_r;
    seq_state_t       state_next_s;
    logic [AW-1:0]    pc_r;
    logic [AW-1:0]    pc_next_s;
    logic [CNT_W-1:0] instret_r;
    logic [CNT_W-1:0] instret_next_s;
    logic             halted_r;
    logic             issue_s;

    // Next-state, next-PC and issue decision; a redirect kills the fetch in any state.
    always_comb begin
        state_next_s   = state_r;
        pc_next_s      = pc_r;
        instret_next_s = instret_r;
        issue_s        = is_issue_state(state_r) & ~bus.redirect_EX;

        case (state_r)
            ST_RUN: begin
                if (bus.halt_req) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (bus.halt_req && bus.step_req) begin
                    state_next_s = ST_STEP;
                end else if (!bus.halt_req) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_STEP: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase

        // Natural AW-bit overflow gives the required modulo-2**AW wrap.
        if (bus.redirect_EX) begin
            pc_next_s = bus.target_EX;
        end else if (issue_s) begin
            pc_next_s = pc_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            pc_next_s = pc_r;
        end

        if (issue_s) begin
            instret_next_s = instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            instret_next_s = instret_r;
        end
    end

    // Sequencer state, PC, retire counter and halted status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_RUN;
            pc_r      <= RESET_PC;
            instret_r <= {CNT_W{1'b0}};
            halted_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            pc_r      <= pc_next_s;
            instret_r <= instret_next_s;
            halted_r  <= (state_next_s == ST_HALT);
        end
    end

    // Reset gates only the outputs so EX sees NOPs while rst_n is held low.
    assign bus.PC_FETCH = pc_r;
    assign bus.issue_EX = issue_s & rst_n;
    assign bus.flush_EX = ~(issue_s & rst_n);
    assign bus.halted   = halted_r;
    assign bus.instret  = instret_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized traffic,
// all compared each cycle against a behavioural model of the sequencer rules.
module tb_fetch_sequencer;

    localparam int AW    = 12;
    localparam int CNT_W = 32;
    localparam int MODE_RUN  = 0;
    localparam int MODE_HALT = 1;
    localparam int MODE_STEP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.AW(AW), .CNT_W(CNT_W)) bus();

    fetch_sequencer #(.AW(AW), .CNT_W(CNT_W), .RESET_PC(12'h000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    int          m_pc;
    int          m_mode;
    int unsigned m_instret;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 0;
        m_mode    = MODE_RUN;
        m_instret = 0;
    endtask

    // Drive one cycle's inputs at the falling edge, check outputs, advance model at rising edge.
    task automatic cycle(input bit red, input int tgt, input bit hr, input bit sr);
        bit exp_issue;
        bus.redirect_EX = red;
        bus.target_EX   = tgt[AW-1:0];
        bus.halt_req    = hr;
        bus.step_req    = sr;
        #1;
        exp_issue = rst_n && (m_mode != MODE_HALT) && !red;
        check("pc",      bus.PC_FETCH, m_pc);
        check("issue",   bus.issue_EX, exp_issue);
        check("flush",   bus.flush_EX, !exp_issue);
        check("halted",  bus.halted,   (m_mode == MODE_HALT));
        check("instret", bus.instret,  m_instret);
        @(posedge clk);
        if (rst_n) begin
            if (red) m_pc = tgt % (1 << AW);
            else if (exp_issue) m_pc = (m_pc + 1) % (1 << AW);
            if (exp_issue) m_instret++;
            case (m_mode)
                MODE_RUN:  if (hr) m_mode = MODE_HALT;
                MODE_HALT: if (!hr) m_mode = MODE_RUN; else if (sr) m_mode = MODE_STEP;
                default:   m_mode = MODE_HALT;
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        bit hr_rand;
        bus.redirect_EX = 1'b0;
        bus.target_EX   = 12'h000;
        bus.halt_req    = 1'b0;
        bus.step_req    = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_issue", bus.issue_EX, 1'b0);
        check("rst_flush", bus.flush_EX, 1'b1);
        rst_n = 1'b1;

        // Straight-line fetch from reset
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 1'b0, 1'b0);
        check("line_pc", bus.PC_FETCH, 12'd10);
        check("line_instret", bus.instret, 32'd10);

        // Redirect at 0x010 costs one flushed slot
        for (int i = 0; i < 6; i++) cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b1, 12'h040, 1'b0, 1'b0);
        check("redir_pc", bus.PC_FETCH, 12'h040);
        check("redir_instret", bus.instret, 32'd16);

        // Halt at 0x020, hold, single step, resume
        cycle(1'b1, 12'h020, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1, 1'b0);
        check("halt_pc", bus.PC_FETCH, 12'h021);
        check("halt_flag", bus.halted, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        check("step_pc", bus.PC_FETCH, 12'h022);
        check("step_halted", bus.halted, 1'b1);
        check("step_instret", bus.instret, 32'd18);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        check("resume_pc", bus.PC_FETCH, 12'h023);

        // Redirect and halt together
        cycle(1'b1, 12'h100, 1'b1, 1'b0);
        check("rh_pc", bus.PC_FETCH, 12'h100);
        check("rh_halted", bus.halted, 1'b1);
        cycle(1'b0, 0, 1'b1, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        check("rh_resume_pc", bus.PC_FETCH, 12'h101);

        // step_req while running is ignored
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1);
        check("step_run_pc", bus.PC_FETCH, 12'h104);

        // PC wrap at the top of the address space
        cycle(1'b1, 12'hFFF, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);
        check("wrap_pc", bus.PC_FETCH, 12'h000);

        // Randomized traffic against the model
        hr_rand = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(7, 0) == 0) hr_rand = ~hr_rand;
            cycle(($urandom_range(5, 0) == 0), int'($urandom_range(4095, 0)),
                  hr_rand, ($urandom_range(2, 0) == 0));
        end
        cycle(1'b0, 0, 1'b0, 1'b0);
        cycle(1'b0, 0, 1'b0, 1'b0);

        // Asynchronous reset mid-run at PC 0x05A
        cycle(1'b1, 12'h05A, 1'b0, 1'b0);
        check("pre_rst_pc", bus.PC_FETCH, 12'h05A);
        rst_n = 1'b0;
        #1;
        check("arst_pc", bus.PC_FETCH, 12'h000);
        check("arst_flush", bus.flush_EX, 1'b1);
        check("arst_instret", bus.instret, 32'd0);
        model_reset();
        @(negedge clk);
        cycle(1'b0, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b0);
        check("post_rst_pc", bus.PC_FETCH, 12'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
